// File: rtl/ss_a2d_mc.sv
// ss_a2d_mc: multi-channel single-slope A2D controller.
// Selects an analog channel through an external mux and waits a settle time.
// Then ramps the DAC one code per STEP_CYC clocks until the comparator trips,
// and latches the crossing code as the result.
// Optional build macro SS_A2D_AVG_EN: average 2^AVG_LOG2 ramp passes per conversion.
module ss_a2d_mc #(
    parameter int unsigned  WIDTH      = 10,
    parameter int unsigned  NUM_CH     = 4,
    parameter int unsigned  SETTLE_CYC = 8,
    parameter int unsigned  STEP_CYC   = 2,
    parameter int unsigned  AVG_LOG2   = 2,
    localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_cnv,
    input  logic [CH_W-1:0]  chnnl,
    input  logic             gt,
    output logic [CH_W-1:0]  mux_sel,
    output logic [WIDTH-1:0] dac,
    output logic [WIDTH-1:0] result,
    output logic             ovr,
    output logic             busy,
    output logic             cnv_cmplt
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned STP_W = $clog2(STEP_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);
    localparam logic [STP_W-1:0] STEP_LOAD   = STP_W'(STEP_CYC - 1);
    localparam logic [WIDTH-1:0] FULL_SCALE  = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StRamp, StDone} state_e;

    state_e           state;
    logic [SET_W-1:0] settle_cnt;
    logic [STP_W-1:0] step_cnt;

    logic [CH_W-1:0]  chnnl_clamped;
    logic             step_last;
    logic             pass_ovf;
    logic             pass_end;

    // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
    if ((2 ** CH_W) > NUM_CH) begin : g_clamp
        localparam logic [CH_W-1:0] MAX_CH = CH_W'(NUM_CH - 1);
        // Clamp the requested channel to the highest implemented one.
        always_comb begin
            chnnl_clamped = (chnnl > MAX_CH) ? MAX_CH : chnnl;
        end
    end else begin : g_no_clamp
        // Every encodable channel exists; pass straight through.
        always_comb begin
            chnnl_clamped = chnnl;
        end
    end

    // Decode the end of a step and whether the current pass finishes on it.
    always_comb begin
        step_last = (step_cnt == '0);
        pass_ovf  = !gt && (dac == FULL_SCALE);
        pass_end  = gt || pass_ovf;
    end

`ifdef SS_A2D_AVG_EN
    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] pass_idx;
    logic                ovr_acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIDTH-1:0]    avg_result;
    logic                last_pass;

    // The ending code of a pass is always dac: the crossing code, or full scale on overflow.
    always_comb begin
        acc_sum    = acc + ACC_W'(dac);
        avg_result = WIDTH'(acc_sum >> AVG_LOG2);
        last_pass  = (pass_idx == '1);
    end
`endif

    // Conversion sequencer; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            settle_cnt <= '0;
            step_cnt   <= '0;
            mux_sel    <= '0;
            dac        <= '0;
            result     <= '0;
            ovr        <= 1'b0;
            busy       <= 1'b0;
            cnv_cmplt  <= 1'b0;
`ifdef SS_A2D_AVG_EN
            acc        <= '0;
            pass_idx   <= '0;
            ovr_acc    <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (strt_cnv) begin
                        mux_sel    <= chnnl_clamped;
                        dac        <= '0;
                        cnv_cmplt  <= 1'b0;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
`ifdef SS_A2D_AVG_EN
                        acc        <= '0;
                        pass_idx   <= '0;
                        ovr_acc    <= 1'b0;
`endif
                        state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt == '0) begin
                        step_cnt <= STEP_LOAD;
                        state    <= StRamp;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                StRamp: begin
                    if (!step_last) begin
                        step_cnt <= step_cnt - 1'b1;
                    end else if (pass_end) begin
`ifdef SS_A2D_AVG_EN
                        if (last_pass) begin
                            result <= avg_result;
                            ovr    <= ovr_acc || pass_ovf;
                            state  <= StDone;
                        end else begin
                            // Re-settle and ramp again on the same channel.
                            acc        <= acc_sum;
                            pass_idx   <= pass_idx + 1'b1;
                            ovr_acc    <= ovr_acc || pass_ovf;
                            dac        <= '0;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= StSettle;
                        end
`else
                        result <= dac;
                        ovr    <= pass_ovf;
                        state  <= StDone;
`endif
                    end else begin
                        dac      <= dac + 1'b1;
                        step_cnt <= STEP_LOAD;
                    end
                end
                StDone: begin
                    cnv_cmplt <= 1'b1;
                    busy      <= 1'b0;
                    dac       <= '0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_a2d_mc.sv
// Self-checking bench for ss_a2d_mc: table of directed conversions plus
// hand-written sequences (reset mid-ramp, 8-bit/8-channel build, channel clamp,
// and the averaging build when SS_A2D_AVG_EN is defined).
module tb_ss_a2d_mc;

`ifdef SS_A2D_AVG_EN
    localparam int NPASS = 4;
`else
    localparam int NPASS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Main DUT: default parameters
    logic       strt_cnv = 1'b0;
    logic [1:0] chnnl = '0;
    logic       gt;
    logic [1:0] mux_sel;
    logic [9:0] dac;
    logic [9:0] result;
    logic       ovr, busy, cnv_cmplt;

    // 8-bit, 8-channel, one clock per step
    logic       b_strt = 1'b0;
    logic [2:0] b_chnnl = '0;
    logic       b_gt;
    logic [2:0] b_mux;
    logic [7:0] b_dac, b_res;
    logic       b_ovr, b_busy, b_cmplt;

    // 4-bit, 3-channel: exercises the channel clamp
    logic       c_strt = 1'b0;
    logic [1:0] c_chnnl = '0;
    logic       c_gt;
    logic [1:0] c_mux;
    logic [3:0] c_dac, c_res;
    logic       c_ovr, c_busy, c_cmplt;

    int         ana [4];
    bit         alt_en = 1'b0;
    logic [1:0] pass_idx = '0;
    logic [9:0] dac_prev = '0;
    int         alt_val;

    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign alt_val = pass_idx[0] ? 'h103 : 'h100;
    assign gt   = (alt_en && mux_sel == 2'd0) ? (int'(dac) >= alt_val)
                                              : (int'(dac) >= ana[mux_sel]);
    assign b_gt = (b_mux == 3'd7) ? (b_dac >= 8'h80) : (b_dac >= 8'h10);
    assign c_gt = (c_mux == 2'd2) ? (c_dac >= 4'h7) : (c_dac >= 4'h3);

    // Count averaging passes: dac drops to 0 while still busy means a new pass began.
    always @(posedge clk) begin
        dac_prev <= dac;
        if (!alt_en) pass_idx <= '0;
        else if (busy && dac == '0 && dac_prev != '0) pass_idx <= pass_idx + 1'b1;
    end

    ss_a2d_mc dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl), .gt(gt),
        .mux_sel(mux_sel), .dac(dac), .result(result), .ovr(ovr), .busy(busy),
        .cnv_cmplt(cnv_cmplt)
    );

    ss_a2d_mc #(.WIDTH(8), .NUM_CH(8), .SETTLE_CYC(8), .STEP_CYC(1), .AVG_LOG2(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .strt_cnv(b_strt), .chnnl(b_chnnl), .gt(b_gt),
        .mux_sel(b_mux), .dac(b_dac), .result(b_res), .ovr(b_ovr), .busy(b_busy),
        .cnv_cmplt(b_cmplt)
    );

    ss_a2d_mc #(.WIDTH(4), .NUM_CH(3), .SETTLE_CYC(1), .STEP_CYC(1), .AVG_LOG2(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .strt_cnv(c_strt), .chnnl(c_chnnl), .gt(c_gt),
        .mux_sel(c_mux), .dac(c_dac), .result(c_res), .ovr(c_ovr), .busy(c_busy),
        .cnv_cmplt(c_cmplt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Single-pass latency scaled to the number of averaging passes.
    function automatic int adj(input int lat1);
        return NPASS * (lat1 - 1) + 1;
    endfunction

    // One conversion on the main DUT. poke: 0 none, 1 strt mid-ramp, 2 strt on the DONE clock.
    task automatic convert(input logic [1:0] ch, input int poke, input int lat_req,
                           output int lat, output int mux_err);
        int n;
        @(negedge clk);
        strt_cnv = 1'b1;
        chnnl    = ch;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        chk("busy_on_start", busy, 1);
        chk("cmplt_cleared", cnv_cmplt, 0);
        n = 0;
        mux_err = 0;
        while (!cnv_cmplt && n < 12000) begin
            if ((poke == 1 && n == 300) || (poke == 2 && n == lat_req - 1)) begin
                strt_cnv = 1'b1;
                chnnl    = ~ch;
            end
            @(posedge clk);
            #1;
            strt_cnv = 1'b0;
            n++;
            if (busy && mux_sel !== ch) mux_err++;
        end
        lat = n;
    endtask

    typedef struct {
        logic [1:0] ch;
        int         ana_val;
        logic [9:0] res;
        logic       ovr;
        int         lat;
        int         poke;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, mux_err, n, lat_req;

        vecs[0] = '{ch: 2'd0, ana_val: 'h100, res: 10'h100, ovr: 1'b0, lat: 524,  poke: 0};
        vecs[1] = '{ch: 2'd1, ana_val: 'h200, res: 10'h200, ovr: 1'b0, lat: 1036, poke: 1};
        vecs[2] = '{ch: 2'd2, ana_val: 'h005, res: 10'h005, ovr: 1'b0, lat: 22,   poke: 0};
        vecs[3] = '{ch: 2'd3, ana_val: 'h400, res: 10'h3FF, ovr: 1'b1, lat: 2058, poke: 0};
        vecs[4] = '{ch: 2'd0, ana_val: 'h100, res: 10'h100, ovr: 1'b0, lat: 524,  poke: 0};
        vecs[5] = '{ch: 2'd3, ana_val: 'h000, res: 10'h000, ovr: 1'b0, lat: 12,   poke: 0};
        vecs[6] = '{ch: 2'd0, ana_val: 'h100, res: 10'h100, ovr: 1'b0, lat: 524,  poke: 2};

        ana[0] = 'h100;
        ana[1] = 'h200;
        ana[2] = 'h005;
        ana[3] = 'h3FF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_dac", dac, 0);
        chk("rst_result", result, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnv_cmplt", cnv_cmplt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            ana[vecs[i].ch] = vecs[i].ana_val;
            lat_req = adj(vecs[i].lat);
            convert(vecs[i].ch, vecs[i].poke, lat_req, lat, mux_err);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_ovr", i), ovr, vecs[i].ovr);
            chk($sformatf("v%0d_latency", i), lat, lat_req);
            chk($sformatf("v%0d_mux_hold", i), mux_err, 0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_cmplt_held", i), cnv_cmplt, 1);
            chk($sformatf("v%0d_mux_after", i), mux_sel, vecs[i].ch);
            chk($sformatf("v%0d_dac_after", i), dac, 0);
        end

        // Asynchronous reset in the middle of a ramp
        @(negedge clk);
        strt_cnv = 1'b1;
        chnnl    = 2'd1;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        repeat (200) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mux_sel", mux_sel, 0);
        chk("midrst_dac", dac, 0);
        chk("midrst_result", result, 0);
        chk("midrst_ovr", ovr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnv_cmplt", cnv_cmplt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(2'd2, 0, adj(22), lat, mux_err);
        chk("recover_result", result, 10'h005);
        chk("recover_latency", lat, adj(22));

        // 8-bit, 8-channel regression on ch7
        @(negedge clk);
        b_strt  = 1'b1;
        b_chnnl = 3'd7;
        @(posedge clk);
        #1;
        b_strt  = 1'b0;
        n = 0;
        mux_err = 0;
        while (!b_cmplt && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (b_busy && b_mux !== 3'd7) mux_err++;
        end
        chk("w8_result", b_res, 8'h80);
        chk("w8_ovr", b_ovr, 0);
        chk("w8_latency", n, adj(139));
        chk("w8_mux_hold", mux_err, 0);

        // chnnl=3 on a 3-channel build clamps to channel 2
        @(negedge clk);
        c_strt  = 1'b1;
        c_chnnl = 2'd3;
        @(posedge clk);
        #1;
        c_strt  = 1'b0;
        chk("clamp_mux_sel", c_mux, 2);
        n = 0;
        while (!c_cmplt && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clamp_result", c_res, 4'h7);
        chk("clamp_latency", n, adj(11));

`ifdef SS_A2D_AVG_EN
        // Alternating 0x100/0x103 across four passes: 0x406 >> 2 = 0x101
        alt_en = 1'b1;
        convert(2'd0, 0, 0, lat, mux_err);
        chk("avg_result", result, 10'h101);
        chk("avg_ovr", ovr, 0);
        chk("avg_passes", pass_idx, 3);
        repeat (20) @(posedge clk);
        #1;
        chk("avg_single_cmplt", busy, 0);
        alt_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
